// File: rtl/heap_arbiter.sv
// Round-robin arbiter sharing one heap memory among several command sources.
// Each legal command is executed by exactly one mem_clock transition.
module heap_arbiter #(
  parameter int unsigned ADDRESS_BITS = 2,
  parameter int unsigned INDEX_BITS   = 1,
  parameter int unsigned DATA_BITS    = 12,
  parameter int unsigned REQUESTERS   = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [REQUESTERS-1:0]              req_valid,
  output logic [REQUESTERS-1:0]              req_ready,
  input  logic [8*REQUESTERS-1:0]            req_action,
  input  logic [ADDRESS_BITS*REQUESTERS-1:0] req_array,
  input  logic [INDEX_BITS*REQUESTERS-1:0]   req_index,
  input  logic [DATA_BITS*REQUESTERS-1:0]    req_in,
  output logic [REQUESTERS-1:0]              rsp_valid,
  output logic [DATA_BITS-1:0]               rsp_out,
  output logic [31:0]                        rsp_error,
  output logic                               mem_clock,
  output logic [7:0]                         mem_action,
  output logic [ADDRESS_BITS-1:0]            mem_array,
  output logic [INDEX_BITS-1:0]              mem_index,
  output logic [DATA_BITS-1:0]               mem_in,
  input  logic [DATA_BITS-1:0]               mem_out,
  input  logic [31:0]                        mem_error,
  output logic                               busy
);

  localparam int unsigned IdxW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam logic [31:0] IllegalActionError = 32'd10000280;

  typedef enum logic [1:0] {StIdle, StStrobe, StCapture, StRespond} state_e;

  state_e                    state;
  logic [IdxW-1:0]           last_grant;
  logic [IdxW-1:0]           owner;
  logic [IdxW-1:0]           grant_idx;
  logic [IdxW-1:0]           cand;
  logic                      grant_any;
  logic [7:0]                sel_action;
  logic [ADDRESS_BITS-1:0]   sel_array;
  logic [INDEX_BITS-1:0]     sel_index;
  logic [DATA_BITS-1:0]      sel_in;
  logic                      sel_legal;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= REQUESTERS; k++) begin
      cand = IdxW'((32'(last_grant) + k) % REQUESTERS);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == StIdle && grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_action = req_action[32'(grant_idx)*8 +: 8];
    sel_array  = req_array[32'(grant_idx)*ADDRESS_BITS +: ADDRESS_BITS];
    sel_index  = req_index[32'(grant_idx)*INDEX_BITS +: INDEX_BITS];
    sel_in     = req_in[32'(grant_idx)*DATA_BITS +: DATA_BITS];
    sel_legal  = (sel_action != 8'd0) && (sel_action <= 8'd30);
  end

  assign busy = (state != StIdle);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= StIdle;
      last_grant <= IdxW'(REQUESTERS - 1);
      owner      <= '0;
      rsp_valid  <= '0;
      rsp_out    <= '0;
      rsp_error  <= '0;
      mem_clock  <= 1'b0;
      mem_action <= '0;
      mem_array  <= '0;
      mem_index  <= '0;
      mem_in     <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        StIdle: begin
          if (grant_any) begin
            mem_action <= sel_action;
            mem_array  <= sel_array;
            mem_index  <= sel_index;
            mem_in     <= sel_in;
            last_grant <= grant_idx;
            owner      <= grant_idx;
            if (sel_legal) begin
              state <= StStrobe;
            end else begin
              // Rejected without touching the heap.
              rsp_out              <= '0;
              rsp_error            <= IllegalActionError;
              rsp_valid[grant_idx] <= 1'b1;
              state                <= StRespond;
            end
          end
        end
        StStrobe: begin
          // A single edge of either polarity executes the heap once.
          mem_clock <= ~mem_clock;
          state     <= StCapture;
        end
        StCapture: begin
          rsp_out          <= mem_out;
          rsp_error        <= mem_error;
          rsp_valid[owner] <= 1'b1;
          state            <= StRespond;
        end
        StRespond: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
